i2c_master_byte: RTL and testbench

//  Single-byte I2C master. Feeds the 8-bit I2C IO-extender slave (7-bit address, default 0x27).
//  On a start request it issues START, address+R/W, then one data byte (write), or receives one byte
//  and NACKs it (read), then STOP. Bus pins are open-drain: the block only pulls low or releases.

---
 rtl/i2c_master_byte.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_master_byte.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, address+R/W, then one byte written or one byte read (master NACK), STOP.
// Bus pins are open-drain: scl_oe/sda_oe = 1 pulls the line low, 0 releases it to the pull-up.
module i2c_master_byte #(
   parameter int unsigned QDIV    = 250,
   parameter logic [6:0]  SLV_ADR = 7'h27
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       rw,
   input  logic       adr_sel,
   input  logic [6:0] adr_in,
   input  logic [7:0] wr_data,
   output logic       ready,
   output logic       done,
   output logic       ack_err,
   output logic [7:0] rd_data,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       scl_in,
   input  logic       sda_in
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_START,
      S_ADDR,
      S_AACK,
      S_WDATA,
      S_WACK,
      S_RDATA,
      S_MNACK,
      S_STOP
   } state_t;

   localparam logic [15:0] QMAX = 16'(QDIV - 1);

   state_t      state_q, state_d;
   logic [15:0] qcnt_q, qcnt_d;
   logic [1:0]  phase_q, phase_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        rw_q, rw_d;
   logic        ack_err_q, ack_err_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic        done_q, done_d;
   logic        scl_oe_q, scl_oe_d;
   logic        sda_oe_q, sda_oe_d;
   logic [1:0]  scl_sync_q, sda_sync_q;

   logic scl_hi, sda_hi, is_bit, q_last, q_tick, slot_end;

   // Line drive for a given state/phase; b is the bit being transmitted in ADDR/WDATA.
   function automatic logic [1:0] line_drive(input state_t s, input logic [1:0] ph, input logic b);
      logic [1:0] drv;
      drv = 2'b00;
      case (s)
         S_START:                            drv = {ph == 2'd3, ph >= 2'd2};
         S_ADDR, S_WDATA:                    drv = {ph <= 2'd1, ~b};
         S_AACK, S_WACK, S_RDATA, S_MNACK:   drv = {ph <= 2'd1, 1'b0};
         S_STOP:                             drv = {ph == 2'd0, ph <= 2'd1};
         default:                            drv = 2'b00;
      endcase
      return drv;
   endfunction

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_in};
         sda_sync_q <= {sda_sync_q[0], sda_in};
      end
   end

   assign scl_hi   = scl_sync_q[1];
   assign sda_hi   = sda_sync_q[1];
   assign is_bit   = state_q inside {S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_MNACK};
   assign q_last   = (qcnt_q == QMAX);
   // Clock stretch: the end of ph2 is held until the slave lets SCL rise.
   assign q_tick   = q_last && !(is_bit && phase_q == 2'd2 && !scl_hi);
   assign slot_end = q_tick && (phase_q == 2'd3);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch can be inferred.
      state_d   = state_q;
      qcnt_d    = qcnt_q;
      phase_d   = phase_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      wdata_d   = wdata_q;
      rw_d      = rw_q;
      ack_err_d = ack_err_q;
      rd_data_d = rd_data_q;
      done_d    = 1'b0;

      if (state_q == S_IDLE) begin
         qcnt_d  = '0;
         phase_d = '0;
      end else if (q_tick) begin
         qcnt_d  = '0;
         phase_d = phase_q + 2'd1;
      end else if (!q_last) begin
         qcnt_d  = qcnt_q + 16'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               rw_d      = rw;
               wdata_d   = wr_data;
               shreg_d   = {(adr_sel ? adr_in : SLV_ADR), rw};
               bit_d     = 3'd7;
               ack_err_d = 1'b0;
               state_d   = S_START;
            end
         end
         S_START: if (slot_end) state_d = S_ADDR;
         S_ADDR, S_WDATA: begin
            if (slot_end) begin
               shreg_d = {shreg_q[6:0], 1'b0};
               bit_d   = bit_q - 3'd1;
               if (bit_q == 3'd0) state_d = (state_q == S_ADDR) ? S_AACK : S_WACK;
            end
         end
         S_AACK: begin
            if (slot_end) begin
               if (sda_hi) begin
                  ack_err_d = 1'b1;
                  state_d   = S_STOP;
               end else if (rw_q) begin
                  state_d   = S_RDATA;
               end else begin
                  shreg_d   = wdata_q;
                  state_d   = S_WDATA;
               end
            end
         end
         S_WACK: begin
            if (slot_end) begin
               ack_err_d = sda_hi;
               state_d   = S_STOP;
            end
         end
         S_RDATA: begin
            if (slot_end) begin
               shreg_d = {shreg_q[6:0], sda_hi};
               bit_d   = bit_q - 3'd1;
               if (bit_q == 3'd0) state_d = S_MNACK;
            end
         end
         S_MNACK: if (slot_end) state_d = S_STOP;
         S_STOP: begin
            if (slot_end) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
               if (rw_q && !ack_err_q) rd_data_d = shreg_q;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Pin drivers are registered from the next state so the open-drain outputs never glitch.
      {scl_oe_d, sda_oe_d} = line_drive(state_d, phase_d, shreg_d[7]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         qcnt_q    <= '0;
         phase_q   <= '0;
         bit_q     <= 3'd7;
         shreg_q   <= '0;
         wdata_q   <= '0;
         rw_q      <= 1'b0;
         ack_err_q <= 1'b0;
         rd_data_q <= '0;
         done_q    <= 1'b0;
         scl_oe_q  <= 1'b0;
         sda_oe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         qcnt_q    <= qcnt_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         wdata_q   <= wdata_d;
         rw_q      <= rw_d;
         ack_err_q <= ack_err_d;
         rd_data_q <= rd_data_d;
         done_q    <= done_d;
         scl_oe_q  <= scl_oe_d;
         sda_oe_q  <= sda_oe_d;
      end
   end

   assign ready   = (state_q == S_IDLE);
   assign done    = done_q;
   assign ack_err = ack_err_q;
   assign rd_data = rd_data_q;
   assign scl_oe  = scl_oe_q;
   assign sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: behavioural I2C slave on the wired-AND bus, expectation queue,
// and a monitor that scores every done pulse against the queued expectation.
module tb_i2c_master_byte;

   localparam int QDIV      = 4;
   localparam int SLOT      = 4 * QDIV;
   localparam int LAT_FULL  = 20 * SLOT;
   localparam int LAT_NACK  = 11 * SLOT;
   localparam int STRETCH   = 50;

   typedef struct {
      string      name;
      bit         ack_err;
      bit         chk_rd;
      logic [7:0] rd;
      logic [7:0] adr_byte;
      bit         chk_wr;
      logic [7:0] wr_byte;
      bit         chk_mack;
      int         rises;
      int         lat_lo;
      int         lat_hi;
      int         acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic       adr_sel = 1'b0;
   logic [6:0] adr_in = '0;
   logic [7:0] wr_data = '0;
   logic       ready, done, ack_err;
   logic [7:0] rd_data;
   logic       scl_oe, sda_oe;
   logic       scl_pull = 1'b0;
   logic       sda_pull = 1'b0;
   logic       scl_pin, sda_pin;

   assign scl_pin = ~(scl_oe | scl_pull);
   assign sda_pin = ~(sda_oe | sda_pull);

   i2c_master_byte #(.QDIV(QDIV), .SLV_ADR(7'h27)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .rw     (rw),
      .adr_sel(adr_sel),
      .adr_in (adr_in),
      .wr_data(wr_data),
      .ready  (ready),
      .done   (done),
      .ack_err(ack_err),
      .rd_data(rd_data),
      .scl_oe (scl_oe),
      .sda_oe (sda_oe),
      .scl_in (scl_pin),
      .sda_in (sda_pin)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_vec = 0;
   int   n_bad = 0;
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_vec++;
      if (act < lo || act > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   function automatic exp_t mk(input string name, input bit ae, input bit crd, input logic [7:0] rd,
                               input logic [7:0] ab, input bit cwr, input logic [7:0] wb,
                               input bit cmack, input int rises, input int lo, input int hi);
      exp_t e;
      e.name = name; e.ack_err = ae; e.chk_rd = crd; e.rd = rd; e.adr_byte = ab;
      e.chk_wr = cwr; e.wr_byte = wb; e.chk_mack = cmack; e.rises = rises;
      e.lat_lo = lo; e.lat_hi = hi; e.acc = 0;
      return e;
   endfunction

   // ---------------- behavioural slave (acts on negedge, away from the DUT edge) ----------------
   bit         sl_present = 1'b1;
   bit         sl_nack_wr = 1'b0;
   logic [7:0] sl_rd_byte = 8'h00;
   bit         stretch_req = 1'b0;
   bit         stretch_used = 1'b0;
   int         stretch_left = 0;
   bit         sl_active = 1'b0;
   bit         sl_addressed = 1'b0;
   bit         sl_rd = 1'b0;
   int         sl_bitn = 0;
   int         sl_byte = 0;
   int         sl_rises = 0;
   logic [7:0] sl_sh = '0;
   logic [7:0] sl_adr_byte = '0;
   logic [7:0] sl_wr_byte = '0;
   logic       sl_master_ack = 1'b0;
   int         sl_start_cyc = 0;
   int         sl_stop_cyc = 0;
   logic       scl_prev = 1'b1;
   logic       sda_prev = 1'b1;

   always @(negedge clk) begin : slave
      logic scl_now, sda_now;
      if (stretch_left > 0) begin
         stretch_left--;
         if (stretch_left == 0) scl_pull = 1'b0;
      end
      if (stretch_req && !stretch_used && sl_active && sl_byte == 0 && sl_bitn == 3 && !scl_oe && !scl_prev) begin
         scl_pull     = 1'b1;
         stretch_left = STRETCH;
         stretch_used = 1'b1;
      end
      scl_now = ~(scl_oe | scl_pull);
      sda_now = ~(sda_oe | sda_pull);
      if (scl_now && scl_prev && sda_prev && !sda_now) begin
         sl_active = 1'b1; sl_bitn = 0; sl_byte = 0; sl_rises = 0; sl_addressed = 1'b0;
         sl_adr_byte = '0; sl_wr_byte = '0; sl_master_ack = 1'b0; sda_pull = 1'b0;
         sl_start_cyc = cyc;
      end else if (scl_now && scl_prev && !sda_prev && sda_now) begin
         sl_active = 1'b0; sda_pull = 1'b0; sl_stop_cyc = cyc;
      end else if (sl_active && scl_now && !scl_prev) begin
         sl_rises++;
         if (sl_bitn < 8) sl_sh = {sl_sh[6:0], sda_now};
         else if (sl_byte == 1 && sl_rd) sl_master_ack = sda_now;
         sl_bitn++;
      end else if (sl_active && !scl_now && scl_prev) begin
         if (sl_bitn == 8) begin
            if (sl_byte == 0) begin
               sl_adr_byte  = sl_sh;
               sl_rd        = sl_sh[0];
               sl_addressed = sl_present && (sl_sh[7:1] == 7'h27);
               sda_pull     = sl_addressed;
            end else if (!sl_rd) begin
               sl_wr_byte = sl_sh;
               sda_pull   = sl_addressed && !sl_nack_wr;
            end else begin
               sda_pull = 1'b0;
            end
         end else if (sl_bitn == 9) begin
            sl_bitn = 0;
            sl_byte++;
            sda_pull = (sl_rd && sl_addressed && sl_byte == 1) ? ~sl_rd_byte[7] : 1'b0;
         end else if (sl_bitn >= 1 && sl_byte == 1 && sl_rd && sl_addressed) begin
            sda_pull = ~sl_rd_byte[7 - sl_bitn];
         end
      end
      scl_prev = ~(scl_oe | scl_pull);
      sda_prev = ~(sda_oe | sda_pull);
   end

   // ---------------- monitor: scores each done pulse ----------------
   always @(negedge clk) begin : monitor
      exp_t e;
      if (done) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_done: got a done pulse at cycle %0d, expected none", cyc);
         end else begin
            e = sb.pop_front();
            check({e.name, " ack_err"}, ack_err, e.ack_err);
            if (e.chk_rd) check({e.name, " rd_data"}, rd_data, e.rd);
            check({e.name, " addr_byte"}, sl_adr_byte, e.adr_byte);
            if (e.chk_wr) check({e.name, " wr_byte"}, sl_wr_byte, e.wr_byte);
            if (e.chk_mack) check({e.name, " master_nack"}, sl_master_ack, 1'b1);
            // SCL rises seen by the slave, including the one that precedes STOP.
            check({e.name, " scl_rises"}, sl_rises, e.rises);
            check_range({e.name, " latency"}, cyc - e.acc, e.lat_lo, e.lat_hi);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic issue(input exp_t e, input bit push, input bit r, input bit asel,
                        input logic [6:0] ain, input logic [7:0] wd);
      for (int i = 0; i < 2000 && !ready; i++) @(negedge clk);
      check({e.name, " ready_before_start"}, ready, 1'b1);
      rw = r; adr_sel = asel; adr_in = ain; wr_data = wd; start = 1'b1;
      e.acc = cyc + 1;
      if (push) sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
      check({name, " done_seen"}, done, 1'b1);
   endtask

   task automatic pulse_busy_start();
      check("busy ready", ready, 1'b0);
      rw = 1'b1; adr_sel = 1'b1; adr_in = 7'h11; wr_data = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int stop_c;
      repeat (3) @(negedge clk);
      check("rst ready", ready, 1'b1);
      check("rst done", done, 1'b0);
      check("rst ack_err", ack_err, 1'b0);
      check("rst rd_data", rd_data, 8'h00);
      check("rst scl_oe", scl_oe, 1'b0);
      check("rst sda_oe", sda_oe, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle scl_oe", scl_oe, 1'b0);
      check("idle sda_oe", sda_oe, 1'b0);

      // Write 0xA5 to the default address, with an ignored start while busy.
      issue(mk("wr_a5", 0, 0, 8'h00, 8'h4E, 1, 8'hA5, 0, 19, LAT_FULL, LAT_FULL), 1, 0, 0, 7'h00, 8'hA5);
      repeat (100) @(negedge clk);
      pulse_busy_start();
      wait_done("wr_a5");
      repeat (5) @(negedge clk);

      // No device: NACK on address, straight to STOP.
      sl_present = 1'b0;
      issue(mk("nack_adr", 1, 0, 8'h00, 8'h4E, 0, 8'h00, 0, 10, LAT_NACK, LAT_NACK), 1, 0, 0, 7'h00, 8'h11);
      wait_done("nack_adr");
      sl_present = 1'b1;
      repeat (20) @(negedge clk);
      check("ack_err held", ack_err, 1'b1);

      // Read 0x3C via the alternate address input.
      sl_rd_byte = 8'h3C;
      issue(mk("rd_3c", 0, 1, 8'h3C, 8'h4F, 0, 8'h00, 1, 19, LAT_FULL, LAT_FULL), 1, 1, 1, 7'h27, 8'h00);
      wait_done("rd_3c");
      repeat (5) @(negedge clk);

      // Read from an absent device leaves rd_data untouched.
      sl_present = 1'b0;
      issue(mk("rd_nack", 1, 1, 8'h3C, 8'h4F, 0, 8'h00, 0, 10, LAT_NACK, LAT_NACK), 1, 1, 0, 7'h00, 8'h00);
      wait_done("rd_nack");
      sl_present = 1'b1;
      repeat (5) @(negedge clk);

      // Slave NACKs the data byte.
      sl_nack_wr = 1'b1;
      issue(mk("wr_nack", 1, 0, 8'h00, 8'h4E, 1, 8'hC7, 0, 19, LAT_FULL, LAT_FULL), 1, 0, 0, 7'h00, 8'hC7);
      wait_done("wr_nack");
      sl_nack_wr = 1'b0;
      repeat (5) @(negedge clk);

      // Clock stretch of 50 clks in ph2 of address bit 3 (two-flop sync adds a few clks of slack).
      stretch_req = 1'b1;
      issue(mk("stretch", 0, 0, 8'h00, 8'h4E, 1, 8'h5A, 0, 19, LAT_FULL + STRETCH - 3, LAT_FULL + STRETCH + 3),
            1, 0, 1, 7'h27, 8'h5A);
      wait_done("stretch");
      stretch_req = 1'b0;
      repeat (5) @(negedge clk);

      // Busy re-pulse then reset mid-ADDR: no done, lines released at once.
      issue(mk("aborted", 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0), 0, 0, 0, 7'h00, 8'h33);
      repeat (29) @(negedge clk);
      pulse_busy_start();
      repeat (3) @(negedge clk);
      check("busy before reset", ready, 1'b0);
      rst_n = 1'b0;
      #1;
      check("abort scl_oe", scl_oe, 1'b0);
      check("abort sda_oe", sda_oe, 1'b0);
      check("abort ready", ready, 1'b1);
      check("abort rd_data", rd_data, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Back-to-back: second start in the same clk that ready returns.
      sl_rd_byte = 8'h96;
      issue(mk("b2b_wr", 0, 0, 8'h00, 8'h4E, 1, 8'h81, 0, 19, LAT_FULL, LAT_FULL), 1, 0, 0, 7'h00, 8'h81);
      wait_done("b2b_wr");
      stop_c = sl_stop_cyc;
      issue(mk("b2b_rd", 0, 1, 8'h96, 8'h4F, 0, 8'h00, 1, 19, LAT_FULL, LAT_FULL), 1, 1, 0, 7'h00, 8'h00);
      for (int i = 0; i < 200 && sl_start_cyc <= stop_c; i++) @(negedge clk);
      check_range("stop_to_start gap", sl_start_cyc - stop_c, QDIV, 1000);
      wait_done("b2b_rd");

      for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
      check("scoreboard drained", sb.size(), 0);
      repeat (10) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
